buscaminas_game_ctrl: RTL and testbench
=======================================

# buscaminas_game_ctrl

Sequencing controller for the 10-cell Buscaminas board. It latches a mine map on `start` and turns switch rising edges into cell reveals, one per cycle. It tracks revealed safe cells, decides win or loss, and drives the active-low seven-segment display. It sits between the board switches and the display, and owns the `game_over` and `win` flags that the rest of the game reads.

## Interface
- `N_CELLS`, 10, number of board cells; one switch per cell.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high; clock `clk`.
- `start`  in  1  synchronous one-cycle pulse that begins or restarts a game.
- `mine_map`  in  N_CELLS  bit i = 1 marks cell i as a mine; sampled only on `start`.
- `switches`  in  N_CELLS  raw board switches, asynchronous to `clk`; a 0→1 transition requests reveal of that cell.
- `game_over`  out  1  high while in LOSE.
- `win`  out  1  high while in WIN.
- `revealed`  out  N_CELLS  bit i = 1 once safe cell i has been revealed.
- `safe_count`  out  4  number of safe cells revealed so far.
- `seg`  out  7  display segments {g,f,e,d,c,b,a}, active-low.
- `state_o`  out  2  current state: IDLE=0, PLAY=1, WIN=2, LOSE=3.

## Operation
- **Input path.** `switches` pass through a 2-flop synchronizer (`s2`) and then a previous-value register (`prev`).
  - `rise = s2 & ~prev & ~revealed & ~pend`.
  - Falling edges are ignored.
- **Pending set `pend[N_CELLS-1:0]`.** In PLAY: `pend_next = (pend & ~grant) | rise`.
  - `grant` is a one-hot selection of the lowest-index set bit of `pend` (fixed priority).
  - Outside PLAY, `pend` is cleared and rises are discarded.
- **Target.** On `start`, register `mine_q <= mine_map` and `target <= N_CELLS - popcount(mine_map)`; `target` is 4 bits.
- **IDLE.** `seg` is blank (7'h7F). On `start`:
  - go to WIN if the new target is 0;
  - otherwise go to PLAY.
  - In both cases clear `revealed`, `safe_count` and `pend`.
- **PLAY.** When `grant != 0`, the granted cell is processed that cycle:
  - If the cell is a mine (`grant & mine_q`), go to LOSE. `revealed` and `safe_count` are unchanged.
  - Otherwise `revealed |= grant` and `safe_count++`. If `safe_count + 1 == target`, go to WIN.
  - At most one cell is processed per cycle.
  - `seg` shows `safe_count` as a hex digit.
- **WIN.** Terminal state. `win` = 1; `seg` shows `safe_count` (hex, so 10 displays as "A").
- **LOSE.** Terminal state. `game_over` = 1; `seg` = 7'b1000000 ("0": segments a–f lit, g dark).
- **Restart.** `start` in any state performs the IDLE load described above. This includes a restart mid-game from PLAY.
- **Decoder values** ({g..a}, active-low):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08
  - any other value = 7F
- **Width rules.** `safe_count` never exceeds `target` ≤ 10, so it cannot wrap.

## Timing
- **Reset values.**
  - State: `state_o` = IDLE.
  - Flags and counters: `game_over` = 0, `win` = 0, `revealed` = 0, `safe_count` = 0.
  - Display: `seg` = 7'h7F.
  - Internal: `pend`, `mine_q`, `target`, `s2` and `prev` all = 0.
  - A reset mid-game returns to these values immediately; no pending reveal survives.
- **All outputs are registered.**
- **`start` latency.** `start` high at edge k: the new state, cleared counters and `seg` are visible after edge k.
- **Switch latency.** A switch rising before edge 1:
  - synchronized at edge 2;
  - `pend` set at edge 3;
  - processed at edge 4, with `revealed`, `safe_count`, state and `seg` updated after edge 4 when `pend` was otherwise empty.
  - Each additional lower-index pending cell adds one cycle.
- **Simultaneous rises.** Multiple rises in one cycle are processed lowest index first, on consecutive cycles.
  - If a mine is processed, LOSE is entered and the remaining `pend` bits are dropped.
- **Rise in the grant cycle.** A rise on a cell arriving in the same cycle that another cell is granted is preserved in `pend`.
- **`start` coincident with a grant.** `start` wins: the grant is discarded.
- **Duplicate requests.** A switch toggled off and on again for an already revealed cell is ignored.

## Test plan
- **Reset.** Assert `reset` mid-PLAY with `pend` non-zero → all outputs return to their reset values asynchronously. Afterwards a switch edge produces no reveal until `start`.
- **Win path.**
  - Stimulus: `mine_map` = 10'b0000000001, `start`, then raise switches 1..9 one at a time.
  - Response: `safe_count` steps 1..9, with `seg` 79, 24, … 10.
  - After the 9th reveal: `win` = 1, state WIN, `seg` = 10. Each reveal arrives 4 cycles after its switch edge.
- **Lose path.**
  - Stimulus: `mine_map` = 10'b0000100000; reveal cell 2, then cell 5.
  - Response: `safe_count` = 1, `game_over` = 1, `seg` = 7'b1000000, `revealed` = 10'b0000000100.
  - Further switch edges change nothing.
- **Simultaneous rises.**
  - Stimulus: `mine_map` = 10'b0000001000; switches 1, 4 and 3 rise in the same cycle.
  - Response: cell 1 is revealed at edge 4 and cell 3 (mine) is processed at edge 5 → LOSE. Cell 4 is never revealed.
- **Edge cases.**
  - `mine_map` = all ones, `start` → WIN on the next edge with `safe_count` = 0.
  - `mine_map` = 0, reveal all 10 cells → WIN with `seg` = 08 ("A").
  - A repeated toggle of a revealed cell → no change.
- **Restart.** `start` during PLAY with 3 cells revealed → `revealed` = 0, `safe_count` = 0 and the new `mine_map` is latched. A reveal pending in the `start` cycle is dropped.

Source files
------------

// File: rtl/buscaminas_game_ctrl_if.sv
// Board-side bundle for the Buscaminas controller: start/mine map/switches in,
// game flags, reveal state and display out.
interface buscaminas_game_ctrl_if #(
  parameter int N_CELLS = 10
);
  logic               start;
  logic [N_CELLS-1:0] mine_map;
  logic [N_CELLS-1:0] switches;
  logic               game_over;
  logic               win;
  logic [N_CELLS-1:0] revealed;
  logic [3:0]         safe_count;
  logic [6:0]         seg;
  logic [1:0]         state_o;

  modport master (
    output start, mine_map, switches,
    input  game_over, win, revealed, safe_count, seg, state_o
  );

  modport slave (
    input  start, mine_map, switches,
    output game_over, win, revealed, safe_count, seg, state_o
  );
endinterface

// File: rtl/buscaminas_game_ctrl.sv
// Buscaminas sequencing controller: latches the mine map, turns switch rises
// into one reveal per cycle, decides win/loss and drives the active-low display.
module buscaminas_game_ctrl #(
  parameter int N_CELLS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  buscaminas_game_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3} state_e;

  state_e             state_q;
  logic [N_CELLS-1:0] s1_q, s2_q, prev_q, pend_q, mine_q, revealed_q;
  logic [3:0]         target_q, safe_count_q;
  logic [6:0]         seg_q;
  logic               win_q, game_over_q;

  logic [N_CELLS-1:0] rise, grant;
  logic [3:0]         safe_count_d, target_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] popcount(input logic [N_CELLS-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_CELLS; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

  // Cells already revealed or already queued never re-enter the pending set
  assign rise         = s2_q & ~prev_q & ~revealed_q & ~pend_q;
  assign safe_count_d = safe_count_q + 4'd1;
  assign target_d     = 4'(N_CELLS) - popcount(bus.mine_map);

  always_comb begin
    grant = '0;
    for (int i = N_CELLS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      s1_q         <= '0;
      s2_q         <= '0;
      prev_q       <= '0;
      pend_q       <= '0;
      mine_q       <= '0;
      revealed_q   <= '0;
      target_q     <= '0;
      safe_count_q <= '0;
      seg_q        <= 7'h7F;
      win_q        <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      s1_q   <= bus.switches;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      // start overrides everything, including a grant in the same cycle
      if (bus.start) begin
        mine_q       <= bus.mine_map;
        target_q     <= target_d;
        revealed_q   <= '0;
        safe_count_q <= '0;
        pend_q       <= '0;
        seg_q        <= hex7(4'd0);
        game_over_q  <= 1'b0;
        if (target_d == 4'd0) begin
          state_q <= WIN;
          win_q   <= 1'b1;
        end else begin
          state_q <= PLAY;
          win_q   <= 1'b0;
        end
      end else begin
        case (state_q)
          PLAY: begin
            pend_q <= (pend_q & ~grant) | rise;
            if ((grant & mine_q) != '0) begin
              state_q     <= LOSE;
              game_over_q <= 1'b1;
              seg_q       <= 7'h40;
              pend_q      <= '0;
            end else if (grant != '0) begin
              revealed_q   <= revealed_q | grant;
              safe_count_q <= safe_count_d;
              seg_q        <= hex7(safe_count_d);
              if (safe_count_d == target_q) begin
                state_q <= WIN;
                win_q   <= 1'b1;
                pend_q  <= '0;
              end
            end
          end
          IDLE: begin
            pend_q <= '0;
            seg_q  <= 7'h7F;
          end
          default: pend_q <= '0;
        endcase
      end
    end
  end

  assign bus.state_o    = state_q;
  assign bus.revealed   = revealed_q;
  assign bus.safe_count = safe_count_q;
  assign bus.seg        = seg_q;
  assign bus.win        = win_q;
  assign bus.game_over  = game_over_q;
endmodule

// File: tb/tb_buscaminas_game_ctrl.sv
// Scoreboard bench for buscaminas_game_ctrl: a reference model predicts every
// reveal (value and arrival cycle) and the bench compares as the DUT reacts.
module tb_buscaminas_game_ctrl;
  localparam int N = 10;
  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_WIN = 2'd2, S_LOSE = 2'd3;
  localparam logic [6:0] SEGTAB [0:10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                           7'h02, 7'h78, 7'h00, 7'h10, 7'h08};

  typedef struct {
    logic [24:0] v;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  logic [N-1:0] m_mine, m_rev, m_sw;
  logic [3:0]   m_safe, m_target;
  logic [1:0]   m_state;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  buscaminas_game_ctrl_if #(.N_CELLS(N)) bus();
  buscaminas_game_ctrl #(.N_CELLS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  // {state, revealed, safe_count, seg, win, game_over}
  function automatic logic [24:0] dut_vec();
    return {bus.state_o, bus.revealed, bus.safe_count, bus.seg, bus.win, bus.game_over};
  endfunction

  function automatic logic [24:0] model_vec();
    logic [6:0] s;
    if (m_state == S_IDLE) s = 7'h7F;
    else if (m_state == S_LOSE) s = 7'h40;
    else s = SEGTAB[m_safe];
    return {m_state, m_rev, m_safe, s, m_state == S_WIN, m_state == S_LOSE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_rev = '0; m_safe = '0; m_mine = '0; m_target = '0;
  endtask

  task automatic do_start(input logic [N-1:0] map);
    bus.mine_map = map;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    m_mine   = map;
    m_target = 4'(N - $countones(map));
    m_rev    = '0;
    m_safe   = '0;
    m_state  = (m_target == 4'd0) ? S_WIN : S_PLAY;
  endtask

  task automatic raise(input logic [N-1:0] mask);
    logic [N-1:0] rises;
    exp_t e;
    int   k;
    rises = mask & ~m_sw & ~m_rev;
    m_sw  = m_sw | mask;
    bus.switches = m_sw;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (rises[i] && m_state == S_PLAY) begin
        if (m_mine[i]) m_state = S_LOSE;
        else begin
          m_rev[i] = 1'b1;
          m_safe   = m_safe + 4'd1;
          if (m_safe == m_target) m_state = S_WIN;
        end
        e.v   = model_vec();
        e.cyc = cyc + 4 + k;
        sbq.push_back(e);
        k++;
      end
    end
  endtask

  task automatic lower(input logic [N-1:0] mask);
    m_sw = m_sw & ~mask;
    bus.switches = m_sw;
    repeat (4) tick();
  endtask

  task automatic drain(input string tag);
    exp_t        e;
    logic [24:0] snap;
    int          n;
    bit          changed;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      snap = dut_vec();
      n = 0;
      changed = 0;
      while (!changed && n < 20) begin
        tick();
        n++;
        if (dut_vec() !== snap) changed = 1;
      end
      checks++;
      if (!changed) begin
        errors++;
        $display("[TB] FAIL %s_timeout: no reveal within %0d cycles, expected %h", tag, n, e.v);
        sbq.delete();
      end else if (dut_vec() !== e.v || cyc != e.cyc) begin
        errors++;
        $display("[TB] FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                 tag, dut_vec(), cyc, e.v, e.cyc);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    model_reset();
    checks++;
    if (dut_vec() !== {S_IDLE, 10'd0, 4'd0, 7'h7F, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected %h", dut_vec(), {S_IDLE, 10'd0, 4'd0, 7'h7F, 2'b00});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    do_start('0);
    m_sw = 10'b0000001110;
    bus.switches = m_sw;
    repeat (3) tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL pre_reset_play: got %h expected %h", dut_vec(), model_vec());
    end
    #1 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", dut_vec(), model_vec());
    end
    tick();
    reset = 1'b0;
    m_sw[5] = 1'b1;
    bus.switches = m_sw;
    repeat (8) tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL idle_ignores_switch: got %h expected %h", dut_vec(), model_vec());
    end
    do_start('0);
    repeat (6) tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL no_pending_survives: got %h expected %h", dut_vec(), model_vec());
    end
    lower(m_sw);
  endtask

  task automatic test_win_path();
    do_start(10'b0000000001);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL win_start: got %h expected %h", dut_vec(), model_vec());
    end
    raise(10'b1 << 1);
    drain("win_reveal1");
    lower(10'b1 << 1);
    raise(10'b1 << 1);
    repeat (8) tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL duplicate_toggle: got %h expected %h", dut_vec(), model_vec());
    end
    for (int i = 2; i < N; i++) begin
      raise(10'b1 << i);
      drain("win_reveal");
    end
    checks++;
    if (bus.win !== 1'b1 || bus.state_o !== S_WIN || bus.seg !== 7'h10) begin
      errors++;
      $display("[TB] FAIL win_final: got win=%b state=%0d seg=%h expected win=1 state=2 seg=10",
               bus.win, bus.state_o, bus.seg);
    end
  endtask

  task automatic test_lose_path();
    lower(m_sw);
    do_start(10'b0000100000);
    raise(10'b1 << 2);
    drain("lose_safe");
    raise(10'b1 << 5);
    drain("lose_mine");
    raise(10'b1 << 7);
    repeat (8) tick();
    checks++;
    if (dut_vec() !== {S_LOSE, 10'b0000000100, 4'd1, 7'h40, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL lose_frozen: got %h expected %h", dut_vec(),
               {S_LOSE, 10'b0000000100, 4'd1, 7'h40, 2'b01});
    end
  endtask

  task automatic test_simultaneous();
    lower(m_sw);
    do_start(10'b0000001000);
    raise(10'b0000011010);
    drain("simul");
    repeat (6) tick();
    checks++;
    if (bus.revealed !== 10'b0000000010 || bus.state_o !== S_LOSE) begin
      errors++;
      $display("[TB] FAIL simul_cell4_dropped: got revealed=%b state=%0d expected 0000000010 state=3",
               bus.revealed, bus.state_o);
    end
  endtask

  task automatic test_all_mines();
    do_start('1);
    checks++;
    if (dut_vec() !== {S_WIN, 10'd0, 4'd0, 7'h40, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL all_mines_win: got %h expected %h", dut_vec(), {S_WIN, 10'd0, 4'd0, 7'h40, 2'b10});
    end
  endtask

  task automatic test_no_mines();
    lower(m_sw);
    do_start('0);
    raise('1);
    drain("no_mines");
    checks++;
    if (bus.seg !== 7'h08 || bus.safe_count !== 4'd10 || bus.win !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_mines_final: got seg=%h safe=%0d win=%b expected seg=08 safe=10 win=1",
               bus.seg, bus.safe_count, bus.win);
    end
  endtask

  task automatic test_restart();
    lower(m_sw);
    do_start('0);
    raise(10'b0000000111);
    drain("restart_pre");
    m_sw[4] = 1'b1;
    bus.switches = m_sw;
    repeat (3) tick();
    do_start(10'b1000000000);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL restart_clear: got %h expected %h", dut_vec(), model_vec());
    end
    repeat (6) tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL restart_grant_dropped: got %h expected %h", dut_vec(), model_vec());
    end
    raise(10'b1 << 9);
    drain("restart_new_map");
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.mine_map = '0;
    bus.switches = '0;
    m_sw         = '0;
    model_reset();
    test_reset();
    test_win_path();
    test_lose_path();
    test_simultaneous();
    test_all_mines();
    test_no_mines();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
